// File: rtl/adc_capture_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_buffer_if
// Brief    : Sample readout stream (data/valid/ready/last) of the capture buffer.
// Revision : 1.0  initial release
// ============================================================================
interface adc_capture_buffer_if #(
    parameter int ADC_BITS = 9
) ();
    logic [ADC_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_buffer
// Brief    : Offset-corrects interleaved TI-ADC frames, captures a triggered
//            burst into a frame buffer and streams it out one sample at a time.
// Revision : 1.0  initial release
// ============================================================================
module adc_capture_buffer #(
    parameter int ADC_WAYS = 8,
    parameter int ADC_BITS = 9,
    parameter int DEPTH    = 64
) (
    input  wire                          adc_clk,
    input  wire                          rst_n,
    input  wire [ADC_WAYS*ADC_BITS-1:0]  adc_data,
    input  wire [ADC_WAYS*ADC_BITS-1:0]  offset,
    input  wire                          arm,
    input  wire                          trigger,
    input  wire                          abort,
    input  wire [$clog2(DEPTH):0]        num_frames,
    adc_capture_buffer_if.master         stream,
    output logic                         done,
    output logic                         busy
);

    localparam int C_FW = ADC_WAYS * ADC_BITS;
    localparam int C_AW = $clog2(DEPTH);
    localparam int C_WW = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1;

    localparam logic [C_AW:0]     C_DEPTH_V  = (C_AW+1)'(DEPTH);
    localparam logic [C_AW-1:0]   C_LAST_MAX = C_AW'(DEPTH - 1);
    localparam logic [C_WW-1:0]   C_WAY_LAST = C_WW'(ADC_WAYS - 1);
    localparam logic [ADC_BITS-1:0] C_SAT_MAX = {1'b0, {(ADC_BITS-1){1'b1}}};
    localparam logic [ADC_BITS-1:0] C_SAT_MIN = {1'b1, {(ADC_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t              r_state;
    logic [C_FW-1:0]     r_raw;
    logic [C_FW-1:0]     r_corr;
    logic [C_FW-1:0]     w_corr;
    logic                r_trig_d1;
    logic                r_trig_d2;
    logic [C_AW-1:0]     r_last_frm;
    logic [C_AW-1:0]     w_nf_last;
    logic [C_AW-1:0]     r_wptr;
    logic [C_AW-1:0]     r_rfrm;
    logic [C_WW-1:0]     r_rway;
    logic                w_we;
    logic [C_FW-1:0]     w_rd_frame;
    logic [ADC_BITS-1:0] w_rd_word;

    logic [C_FW-1:0]     mem [DEPTH];

    // Per-way correction: flip MSB to go offset-binary -> signed, subtract
    // the offset one bit wider, then clamp back into ADC_BITS.
    for (genvar k = 0; k < ADC_WAYS; k++) begin : g_way
        logic signed [ADC_BITS:0] w_s;
        logic signed [ADC_BITS:0] w_o;
        logic signed [ADC_BITS:0] w_d;

        assign w_s = {~r_raw[k*ADC_BITS+ADC_BITS-1], ~r_raw[k*ADC_BITS+ADC_BITS-1],
                      r_raw[k*ADC_BITS +: ADC_BITS-1]};
        assign w_o = {offset[k*ADC_BITS+ADC_BITS-1], offset[k*ADC_BITS +: ADC_BITS]};
        assign w_d = w_s - w_o;

        assign w_corr[k*ADC_BITS +: ADC_BITS] =
            (w_d[ADC_BITS] == w_d[ADC_BITS-1]) ? w_d[ADC_BITS-1:0] :
            (w_d[ADC_BITS] ? C_SAT_MIN : C_SAT_MAX);
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw  <= '0;
            r_corr <= '0;
        end else begin
            r_raw  <= adc_data;
            r_corr <= w_corr;
        end
    end

    // Triggers only count when they arrive in ARMED; a trigger coinciding
    // with arm in IDLE therefore never reaches the FSM.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_d1 <= 1'b0;
            r_trig_d2 <= 1'b0;
        end else begin
            r_trig_d1 <= trigger   && (r_state == S_ARMED) && !abort;
            r_trig_d2 <= r_trig_d1 && (r_state == S_ARMED) && !abort;
        end
    end

    always_comb begin
        w_nf_last = C_AW'(num_frames - 1'b1);
        if ((num_frames == '0) || (num_frames > C_DEPTH_V)) begin
            w_nf_last = C_LAST_MAX;
        end
    end

    always_comb begin
        w_we = 1'b0;
        if (!abort) begin
            if ((r_state == S_ARMED) && r_trig_d2) begin
                w_we = 1'b1;
            end else if (r_state == S_CAPTURE) begin
                w_we = 1'b1;
            end
        end
    end

    // Frame buffer holds no reset; only entries written this capture are read.
    always_ff @(posedge adc_clk) begin
        if (w_we) begin
            mem[r_wptr] <= r_corr;
        end
    end

    assign w_rd_frame = mem[r_rfrm];

    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < ADC_WAYS; k++) begin
            if (r_rway == C_WW'(k)) begin
                w_rd_word = w_rd_frame[k*ADC_BITS +: ADC_BITS];
            end
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_last_frm       <= '0;
            r_wptr           <= '0;
            r_rfrm           <= '0;
            r_rway           <= '0;
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_state          <= S_IDLE;
                r_wptr           <= '0;
                r_rfrm           <= '0;
                r_rway           <= '0;
                stream.out_valid <= 1'b0;
                stream.out_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_state    <= S_ARMED;
                            r_last_frm <= w_nf_last;
                        end
                    end
                    S_ARMED, S_CAPTURE: begin
                        if (w_we) begin
                            r_wptr <= r_wptr + 1'b1;
                            if (r_wptr == r_last_frm) begin
                                r_state <= S_READOUT;
                            end else begin
                                r_state <= S_CAPTURE;
                            end
                        end
                    end
                    S_READOUT: begin
                        // Output register reloads only when empty or just consumed.
                        if (!stream.out_valid || stream.out_ready) begin
                            if (stream.out_valid && stream.out_last) begin
                                r_state          <= S_IDLE;
                                r_wptr           <= '0;
                                r_rfrm           <= '0;
                                r_rway           <= '0;
                                stream.out_valid <= 1'b0;
                                stream.out_last  <= 1'b0;
                                done             <= 1'b1;
                            end else begin
                                stream.out_data  <= w_rd_word;
                                stream.out_valid <= 1'b1;
                                stream.out_last  <= (r_rfrm == r_last_frm) && (r_rway == C_WAY_LAST);
                                if (r_rway == C_WAY_LAST) begin
                                    r_rway <= '0;
                                    r_rfrm <= r_rfrm + 1'b1;
                                end else begin
                                    r_rway <= r_rway + 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_buffer
// Brief    : Randomised scoreboard bench for adc_capture_buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_buffer;

    localparam int W  = 8;
    localparam int B  = 9;
    localparam int D  = 64;
    localparam int FW = W * B;
    localparam int NW = $clog2(D) + 1;

    typedef struct packed {
        logic [B-1:0] data;
        logic         last;
    } exp_t;

    logic          adc_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [FW-1:0] adc_data = '0;
    logic [FW-1:0] offset   = '0;
    logic          arm      = 1'b0;
    logic          trigger  = 1'b0;
    logic          abort    = 1'b0;
    logic [NW-1:0] num_frames = '0;
    logic          done;
    logic          busy;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            hs_total = 0;
    int            rdy_mode = 0;
    logic [FW-1:0] const_frame = '0;
    exp_t          sb_q[$];

    always #5 adc_clk = ~adc_clk;

    adc_capture_buffer_if #(.ADC_BITS(B)) stream ();

    adc_capture_buffer #(.ADC_WAYS(W), .ADC_BITS(B), .DEPTH(D)) dut (
        .adc_clk    (adc_clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .offset     (offset),
        .arm        (arm),
        .trigger    (trigger),
        .abort      (abort),
        .num_frames (num_frames),
        .stream     (stream),
        .done       (done),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: offset-binary to signed integer, subtract, clamp.
    function automatic logic [B-1:0] model(input logic [B-1:0] raw, input logic [B-1:0] off);
        int s, o, d;
        s = int'(raw) - (1 << (B-1));
        o = int'($signed(off));
        d = s - o;
        if (d > (1 << (B-1)) - 1) d = (1 << (B-1)) - 1;
        if (d < -(1 << (B-1)))    d = -(1 << (B-1));
        return B'(d);
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < W; k++) f[k*B +: B] = B'($urandom);
        return f;
    endfunction

    function automatic logic [FW-1:0] ramp_frame(input int n);
        logic [FW-1:0] f;
        for (int k = 0; k < W; k++) f[k*B +: B] = B'(32'h100 + 8*n + k);
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_offsets();
        logic [FW-1:0] f;
        for (int k = 0; k < W; k++) f[k*B +: B] = B'($urandom_range(0, 80)) - B'(40);
        return f;
    endfunction

    task automatic next_cycle();
        @(posedge adc_clk);
        #2;
    endtask

    initial begin
        stream.out_ready = 1'b1;
        forever begin
            @(posedge adc_clk);
            #2;
            case (rdy_mode)
                0:       stream.out_ready = 1'b1;
                1:       stream.out_ready = ~stream.out_ready;
                default: stream.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: mid-cycle sampling sees exactly what the next edge will see.
    initial begin
        exp_t          e;
        bit            exp_done;
        bit            stall_hold;
        logic [B-1:0]  held_data;
        logic          held_last;
        exp_done   = 1'b0;
        stall_hold = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge adc_clk);
            if (!rst_n) begin
                exp_done   = 1'b0;
                stall_hold = 1'b0;
            end else begin
                check("done_pulse", 32'(done), 32'(exp_done));
                exp_done = 1'b0;
                if (stall_hold) begin
                    check("stall_valid", 32'(stream.out_valid), 32'd1);
                    check("stall_data", 32'(stream.out_data), 32'(held_data));
                    check("stall_last", 32'(stream.out_last), 32'(held_last));
                end
                stall_hold = 1'b0;
                if (stream.out_valid && !abort) begin
                    if (stream.out_ready) begin
                        hs_total++;
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_sample: got %0h, expected no sample", stream.out_data);
                        end else begin
                            e = sb_q.pop_front();
                            check("sample_data", 32'(stream.out_data), 32'(e.data));
                            check("sample_last", 32'(stream.out_last), 32'(e.last));
                            exp_done = e.last;
                        end
                    end else begin
                        stall_hold = 1'b1;
                        held_data  = stream.out_data;
                        held_last  = stream.out_last;
                    end
                end
            end
        end
    end

    task automatic run_capture(input int nf, input int dmode, input bit arm_trig, input int abort_at);
        int            cnt, t, limit, base;
        bit            fin;
        exp_t          e;
        logic [FW-1:0] f;
        cnt  = (nf == 0 || nf > D) ? D : nf;
        base = hs_total;
        num_frames = NW'(nf);
        arm      = 1'b1;
        trigger  = arm_trig;
        adc_data = rand_frame();
        next_cycle();
        arm     = 1'b0;
        trigger = 1'b0;
        check("busy_armed", 32'(busy), 32'd1);
        repeat ($urandom_range(0, 3)) begin
            adc_data = rand_frame();
            next_cycle();
        end
        for (int n = 0; n < cnt; n++) begin
            case (dmode)
                0:       f = rand_frame();
                1:       f = const_frame;
                default: f = ramp_frame(n);
            endcase
            adc_data = f;
            trigger  = (n == 0);
            for (int k = 0; k < W; k++) begin
                e.data = model(f[k*B +: B], offset[k*B +: B]);
                e.last = (n == cnt - 1) && (k == W - 1);
                sb_q.push_back(e);
            end
            next_cycle();
        end
        trigger = 1'b0;
        limit = cnt * W * 8 + 50;
        t   = 0;
        fin = 1'b0;
        while (!fin && t < limit) begin
            if (done) begin
                fin = 1'b1;
            end else if (abort_at >= 0 && (hs_total - base) == abort_at && stream.out_valid) begin
                trigger = 1'b0;
                abort   = 1'b1;
                next_cycle();
                abort = 1'b0;
                sb_q.delete();
                check("abort_valid", 32'(stream.out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                repeat (4) next_cycle();
                fin = 1'b1;
            end else begin
                adc_data = rand_frame();
                trigger  = ($urandom_range(0, 7) == 0);
                next_cycle();
                t++;
            end
        end
        trigger = 1'b0;
        check("capture_finished", 32'(fin), 32'd1);
        if (abort_at < 0) begin
            check("busy_after_done", 32'(busy), 32'd0);
            check("sb_drained", 32'(sb_q.size()), 32'd0);
            check("sample_count", 32'(hs_total - base), 32'(cnt * W));
        end else begin
            check("abort_sample_count", 32'(hs_total - base), 32'(abort_at));
        end
        sb_q.delete();
        repeat (2) next_cycle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge adc_clk);
        #1;
        check("rst_valid", 32'(stream.out_valid), 32'd0);
        check("rst_last", 32'(stream.out_last), 32'd0);
        check("rst_data", 32'(stream.out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        next_cycle();

        // Triggers while IDLE must not start anything.
        trigger = 1'b1;
        repeat (3) next_cycle();
        trigger = 1'b0;
        check("idle_trigger_busy", 32'(busy), 32'd0);

        // Offset zero, saturating corner codes.
        offset = '0;
        const_frame = {W{9'h100}}; run_capture(1, 1, 1'b0, -1);
        const_frame = {W{9'h1FF}}; run_capture(1, 1, 1'b0, -1);
        const_frame = {W{9'h000}}; run_capture(1, 1, 1'b0, -1);

        // Way 3 directed corrections, other ways random.
        offset = rand_offsets(); offset[3*B +: B] = -9'sd10;
        const_frame = rand_frame(); const_frame[3*B +: B] = 9'h1FF;
        run_capture(1, 1, 1'b0, -1);
        offset[3*B +: B] = 9'd5;
        const_frame = rand_frame(); const_frame[3*B +: B] = 9'h000;
        run_capture(1, 1, 1'b0, -1);
        offset[3*B +: B] = 9'd16;
        const_frame = rand_frame(); const_frame[3*B +: B] = 9'h120;
        run_capture(1, 1, 1'b0, -1);

        // Ramp burst, free-flowing then alternating backpressure.
        offset = '0;
        rdy_mode = 0; run_capture(2, 2, 1'b0, -1);
        rdy_mode = 1; run_capture(2, 2, 1'b1, -1);

        // Randomised captures including clamped counts.
        for (int i = 0; i < 6; i++) begin
            offset   = rand_offsets();
            rdy_mode = 2;
            run_capture($urandom_range(0, D + 6), 0, 1'($urandom_range(0, 1)), -1);
        end

        // Abort on the 5th readout sample, then a clean capture.
        offset = '0;
        rdy_mode = 0; run_capture(2, 2, 1'b0, 4);
        run_capture(2, 2, 1'b0, -1);

        // Reset during CAPTURE.
        offset = rand_offsets();
        num_frames = NW'(3);
        arm = 1'b1;
        next_cycle();
        arm = 1'b0;
        trigger = 1'b1;
        adc_data = rand_frame();
        next_cycle();
        trigger = 1'b0;
        repeat (3) begin
            adc_data = rand_frame();
            next_cycle();
        end
        check("busy_in_capture", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(stream.out_valid), 32'd0);
        check("midrst_last", 32'(stream.out_last), 32'd0);
        check("midrst_data", 32'(stream.out_data), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        sb_q.delete();
        repeat (4) begin
            next_cycle();
            check("post_rst_idle_busy", 32'(busy), 32'd0);
            check("post_rst_idle_valid", 32'(stream.out_valid), 32'd0);
        end
        rdy_mode = 2;
        run_capture(0, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_buffer.md
ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 Parameter ADC_WAYS, default 8, number of interleaved sub-ADC ways per frame.
REQ-002 Parameter ADC_BITS, default 9, width of each sub-ADC word.
REQ-003 Parameter DEPTH, default 64, capture depth in frames; power of two.
REQ-004 adc_clk  in  1  ADC core clock (TI-ADC CLKOUT domain); single clock of the block.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 adc_data  in  ADC_WAYS*ADC_BITS  retimed frame; way k at bits [k*ADC_BITS +: ADC_BITS]; offset-binary; MSB = highest bit.
REQ-007 offset  in  ADC_WAYS*ADC_BITS  per-way two's-complement offset, same packing as adc_data.
REQ-008 arm  in  1  arms capture when in IDLE.
REQ-009 trigger  in  1  starts capture when in ARMED; time-aligned with adc_data.
REQ-010 abort  in  1  returns to IDLE from any state.
REQ-011 num_frames  in  log2(DEPTH)+1  frames to capture; 0 or >DEPTH means DEPTH.
REQ-012 out_data  out  ADC_BITS  corrected sample, two's complement.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_ready  in  1  downstream accepts sample.
REQ-015 out_last  out  1  marks final sample of capture.
REQ-016 done  out  1  one-cycle pulse after final sample handshake.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 Stage 1 shall register adc_data every cycle; stage 2 shall produce corrected frame: per way s = raw with MSB inverted (signed), d = s - offset at ADC_BITS+1 bits, saturated to [-2^(ADC_BITS-1), 2^(ADC_BITS-1)-1]; total latency 2 cycles.
REQ-019 trigger shall be delayed 2 cycles internally so the frame present on adc_data with trigger is captured as frame 0.
REQ-020 FSM states: IDLE(0), ARMED(1), CAPTURE(2), READOUT(3).
REQ-021 IDLE: arm=1 -> ARMED next cycle; num_frames latched on that edge (0/>DEPTH clamped to DEPTH).
REQ-022 ARMED: delayed trigger=1 -> CAPTURE; frame written at that cycle is frame 0.
REQ-023 CAPTURE: one corrected frame written per cycle at incrementing write pointer, no gaps; after latched count written -> READOUT.
REQ-024 Last write at cycle c: state READOUT at c+1; out_valid first high at c+2 (synchronous buffer read).
REQ-025 READOUT order: frame 0 way 0..ADC_WAYS-1, then frame 1, ...; advance only on out_valid&&out_ready.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_last shall hold stable; out_valid shall not drop until handshake.
REQ-027 out_last high only with sample (count-1, way ADC_WAYS-1); its handshake -> IDLE next cycle, done=1 that cycle, out_valid=0.
REQ-028 arm outside IDLE ignored; trigger outside ARMED ignored; arm and raw trigger same cycle in IDLE: arm accepted, trigger ignored.
REQ-029 abort=1 (priority over all): IDLE next cycle, out_valid/out_last=0, done not pulsed, pointers cleared, buffer contents discarded.
REQ-030 Datapath stages 1-2 run continuously in every state.

Reset
REQ-031 rst_n=0 shall asynchronously force: state IDLE, pipeline registers 0, pointers 0, out_data 0, out_valid 0, out_last 0, done 0, busy 0.
REQ-032 Reset mid-capture or mid-readout shall discard capture; after rst_n rises, block waits in IDLE for arm.
REQ-033 Buffer contents need no reset; no uninitialised entry shall ever be output.

Verification
REQ-034 offset=0; all ways raw 0x100/0x1FF/0x000 -> out samples 0/+255/-256.
REQ-035 Way 3 raw 0x1FF, offset -10 -> +255 (sat); raw 0x000, offset +5 -> -256 (sat); way 3 raw 0x120, offset +16 -> +16.
REQ-036 num_frames=2, frame n way k raw = 0x100+8n+k, trigger with n=0, out_ready=1 -> 16 samples 0..15 in order, out_last on 16th, done one cycle later.
REQ-037 Same capture, out_ready toggling 1010... -> identical 16-sample sequence, held data stable on stalls, no drop/duplicate.
REQ-038 abort at 5th readout sample -> out_valid 0 and busy 0 next cycle, no done; new arm/trigger captures correctly.
REQ-039 rst_n low during CAPTURE -> all outputs at reset values immediately; num_frames=0 capture afterwards -> exactly 512 samples.
